// File: rtl/overdrive_clamp_inverse.sv
// rtl/overdrive_clamp_inverse.sv - bisection inverse of the Q12 cubic soft-clip shaper
//
// Purpose: given a shaped sample y, finds the smallest pre-shape sample x in
// [-(One-1), One-1] with f(x) >= y by a fixed-length bisection (ITERS edges).
// Samples outside the reachable output range clamp to the domain ends and
// raise o_sat.
//
// Ports:
//   i_clk        clock, all state on rising edge
//   i_rst_n      asynchronous active-low reset
//   i_valid      input sample valid
//   o_in_ready   block is idle and can accept a sample
//   i_sample     shaped sample y, signed Q(FRAC)
//   o_valid      result valid, held until i_out_ready
//   i_out_ready  downstream accepts result
//   o_sample     recovered sample x, signed Q(FRAC)
//   o_sat        y was outside [f(-(One-1)), f(One-1)], result clamped
module overdrive_clamp_inverse #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 12,
  parameter int ITERS = 13
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_in_ready,
  input  logic signed [WIDTH-1:0] i_sample,
  output logic                    o_valid,
  input  logic                    i_out_ready,
  output logic signed [WIDTH-1:0] o_sample,
  output logic                    o_sat
);

  localparam int ONE   = 1 << FRAC;
  localparam int XMAX  = ONE - 1;
  localparam int CNT_W = $clog2(ITERS + 1);

  localparam logic signed [31:0] M_BIAS = 32'(ONE - 1);

  // Q(FRAC) multiply with truncation toward zero: bias negative products
  // before the arithmetic shift so the shift rounds toward zero, not down.
  function automatic logic signed [31:0] mul_q(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
    logic signed [31:0] p;
    p = a * b;
    return (p + (p[31] ? M_BIAS : 32'sd0)) >>> FRAC;
  endfunction

  // Soft-clip shaper f(v) = trunc((v^3/One^2 + 3v) / 4), valid for |v| < One.
  function automatic logic signed [31:0] shape(input logic signed [31:0] v);
    logic signed [31:0] s;
    s = mul_q(mul_q(v, v), v) + 3 * v;
    return (s + (s[31] ? 32'sd3 : 32'sd0)) >>> 2;
  endfunction

  // Reachable output range; f is odd so the lower bound is the negation.
  localparam logic signed [31:0] Y_MAX = shape(32'(XMAX));
  localparam logic signed [31:0] Y_MIN = -Y_MAX;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic signed [WIDTH-1:0] y_q, y_d;
  logic signed [31:0]      lo_q, lo_d;
  logic signed [31:0]      hi_q, hi_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [WIDTH-1:0] o_sample_q, o_sample_d;
  logic                    o_sat_q, o_sat_d;

  logic signed [31:0]      mid;
  logic signed [31:0]      f_mid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      y_q        <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      cnt_q      <= '0;
      o_sample_q <= '0;
      o_sat_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      cnt_q      <= cnt_d;
      o_sample_q <= o_sample_d;
      o_sat_q    <= o_sat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    cnt_d      = cnt_q;
    o_sample_d = o_sample_q;
    o_sat_d    = o_sat_q;
    mid        = (lo_q + hi_q) >>> 1;
    f_mid      = shape(mid);

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          y_d     = i_sample;
          lo_d    = -32'(XMAX);
          hi_d    = 32'(XMAX);
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (lo_q != hi_q) begin
          if (f_mid >= y_q) begin
            hi_d = mid;
          end else begin
            lo_d = mid + 32'sd1;
          end
        end
        // Out-of-range y needs no special case: the search converges to the
        // domain end on its own, so only the flag is derived separately.
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          state_d    = DONE;
          o_sample_d = WIDTH'(lo_d);
          o_sat_d    = (y_q > Y_MAX) || (y_q < Y_MIN);
        end
      end
      DONE: begin
        if (i_out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_in_ready = (state_q == IDLE);
  assign o_valid    = (state_q == DONE);
  assign o_sample   = o_sample_q;
  assign o_sat      = o_sat_q;

endmodule

// File: tb/tb_overdrive_clamp_inverse.sv
// tb/tb_overdrive_clamp_inverse.sv - scoreboard bench for overdrive_clamp_inverse
module tb_overdrive_clamp_inverse;

  localparam int WIDTH = 32;

  logic                    i_clk = 1'b0;
  logic                    i_rst_n;
  logic                    i_valid;
  logic                    o_in_ready;
  logic signed [WIDTH-1:0] i_sample;
  logic                    o_valid;
  logic                    i_out_ready;
  logic signed [WIDTH-1:0] o_sample;
  logic                    o_sat;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int y;
    int x;
    bit sat;
    bit rt;
  } exp_t;

  exp_t sb[$];
  int   ftab[-4095:4095];

  always #5 i_clk = ~i_clk;

  overdrive_clamp_inverse #(
    .WIDTH(WIDTH),
    .FRAC (12),
    .ITERS(13)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_in_ready (o_in_ready),
    .i_sample   (i_sample),
    .o_valid    (o_valid),
    .i_out_ready(i_out_ready),
    .o_sample   (o_sample),
    .o_sat      (o_sat)
  );

  function automatic int m_model(input int a, input int b);
    return (a * b) / 4096;
  endfunction

  function automatic int f_model(input int v);
    return (m_model(m_model(v, v), v) + 3 * v) / 4;
  endfunction

  function automatic int inv_model(input int y);
    for (int x = -4095; x <= 4095; x++) begin
      if (ftab[x] >= y) return x;
    end
    return 4095;
  endfunction

  task automatic check(input string tag, input longint got, input longint expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  // Drives one sample; returns at the negedge following the accept edge.
  task automatic accept(input int y, input bit rt);
    int w;
    exp_t e;
    w = 0;
    while (o_in_ready !== 1'b1 && w < 50) begin
      @(negedge i_clk);
      w++;
    end
    check("accept_ready", o_in_ready, 1);
    i_sample = y;
    i_valid  = 1'b1;
    e.y   = y;
    e.x   = inv_model(y);
    e.sat = (y > 4094) || (y < -4094);
    e.rt  = rt;
    sb.push_back(e);
    @(negedge i_clk);
    i_valid = 1'b0;
    check("busy_in_ready", o_in_ready, 0);
    check("busy_valid", o_valid, 0);
  endtask

  // Waits for the result, optionally back-pressures, compares and consumes.
  task automatic finish(input int hold, input bit pulse);
    int   lat;
    int   idx;
    exp_t e;
    lat = 0;
    while (o_valid !== 1'b1 && lat < 40) begin
      @(negedge i_clk);
      lat++;
    end
    check("latency", lat, 13);
    if (sb.size() == 0) begin
      check("sb_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    check("sample", o_sample, e.x);
    check("sat", o_sat, e.sat);
    if (e.rt) begin
      idx = o_sample;
      check("roundtrip", (idx >= -4095 && idx <= 4095) ? ftab[idx] : 99999, e.y);
    end
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin
        i_sample = 0;
        i_valid  = (i % 4 == 1);
      end
      @(negedge i_clk);
      check("hold_valid", o_valid, 1);
      check("hold_sample", o_sample, e.x);
      check("hold_sat", o_sat, e.sat);
      check("hold_in_ready", o_in_ready, 0);
    end
    i_valid     = 1'b0;
    i_out_ready = 1'b1;
    @(negedge i_clk);
    i_out_ready = 1'b0;
    check("consumed_valid", o_valid, 0);
    check("consumed_ready", o_in_ready, 1);
  endtask

  initial begin
    for (int x = -4095; x <= 4095; x++) ftab[x] = f_model(x);

    i_rst_n     = 1'b0;
    i_valid     = 1'b0;
    i_out_ready = 1'b0;
    i_sample    = '0;
    repeat (3) @(negedge i_clk);
    check("rst_in_ready", o_in_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_sample", o_sample, 0);
    check("rst_sat", o_sat, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    accept(0, 1'b0);     finish(0, 1'b0);
    accept(3, 1'b0);     finish(0, 1'b0);
    accept(4094, 1'b0);  finish(0, 1'b0);
    accept(-4094, 1'b0); finish(0, 1'b0);
    accept(5000, 1'b0);  finish(20, 1'b1);
    accept(-5000, 1'b0); finish(0, 1'b0);

    // Asynchronous reset part-way through a search (counter at 6).
    accept(3, 1'b0);
    repeat (6) @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("midrst_valid", o_valid, 0);
    check("midrst_in_ready", o_in_ready, 1);
    check("midrst_sample", o_sample, 0);
    check("midrst_sat", o_sat, 0);
    if (sb.size() > 0) sb.delete(sb.size() - 1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    accept(3, 1'b0);     finish(0, 1'b0);

    // Round-trip sweep over the domain (every 4th point plus the top end).
    for (int x = -4095; x <= 4095; x += 4) begin
      accept(ftab[x], 1'b1);
      finish(0, 1'b0);
    end
    accept(ftab[4095], 1'b1);
    finish(0, 1'b0);

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/overdrive_clamp_inverse.md
Name: overdrive_clamp_inverse

Overview:
- Sequential inverter of the Q12 cubic soft-clip waveshaper used by the overdrive path.
- Given a shaped sample y, it bisects the search domain to find the smallest pre-shape sample x with f(x) >= y.
- It sits beside the overdrive stage as the decode-side partner. It serves gain-calibration and round-trip self-check logic, and accepts one sample per transaction over valid/ready handshakes.

Parameters:
- WIDTH, 32, signed sample width on i_sample/o_sample (int-compatible).
- FRAC, 12, fractional bits; One = 2**FRAC = 4096.
- ITERS, 13, bisection iterations; must satisfy 2**ITERS >= 2*One-1.

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  input sample valid.
- o_in_ready  output  1  block can accept a sample.
- i_sample  input  WIDTH  shaped sample y, signed Q12.
- o_valid  output  1  result valid.
- i_out_ready  input  1  downstream accepts result.
- o_sample  output  WIDTH  recovered sample x, signed Q12, range [-4095, 4095].
- o_sat  output  1  y outside [f(-4095), f(4095)] = [-4094, 4094]; result clamped.

Behaviour:
- Shaping function, bit-exact with signed truncating (toward zero) division:
  - m(a,b) = trunc(a*b/One).
  - f(v) = trunc((m(m(v,v),v) + 3*v)/4) for -4095 <= v <= 4095.
  - f is monotonic nondecreasing on this domain. The clamp discontinuity at |v| >= One lies outside the domain and is never evaluated.
- Internal products: v*v needs <= 25 bits signed and 3*v needs <= 15 bits; use >= 32-bit signed intermediates with no overflow.
- States:
  - IDLE: o_in_ready=1, o_valid=0.
  - BUSY: o_in_ready=0, o_valid=0.
  - DONE: o_in_ready=0, o_valid=1.
- IDLE to BUSY on i_valid & o_in_ready at edge E. That edge latches y=i_sample and sets lo=-4095, hi=4095, cnt=0.
- BUSY, one iteration per edge:
  - mid = floor((lo+hi)/2), using an arithmetic shift.
  - If f(mid) >= y then hi=mid, else lo=mid+1.
  - If lo==hi already, hold lo and hi.
  - cnt increments each edge.
  - Exactly ITERS edges in BUSY regardless of data; the iteration count is fixed.
- The ITERS-th BUSY edge (E+13) moves to DONE and registers o_sample=lo and o_sat=(y>4094)|(y<-4094). o_valid is high from that edge on. Latency from accept edge to o_valid = 13 cycles.
- DONE: o_sample, o_sat and o_valid hold stable until i_out_ready=1 at an edge; then go to IDLE with o_valid=0.
- No overlap: a new input is not accepted in the same cycle the result is consumed. Throughput is one sample per 15 cycles minimum.
- i_valid while not in IDLE is ignored; the caller must hold it.
- Saturation results:
  - y > 4094 gives o_sample=4095, o_sat=1.
  - y < -4094 gives o_sample=-4095, o_sat=1.
  - y = 4094 gives o_sample=4095, o_sat=0.
  - y = -4094 gives o_sample=-4095, o_sat=0.
- Truncation plateaus where several x map to the same y: the smallest such x is returned. Example: f(-1)=f(0)=0, so y=0 yields -1.
- Reset values, asynchronous, any state including mid-BUSY: state=IDLE, o_in_ready=1, o_valid=0, o_sample=0, o_sat=0, lo/hi/cnt/y=0. The in-flight transaction is discarded.
- Inputs wider than the domain are handled by the saturation rule above; there is no wrap-around.

Test Plan:
- Reset then y=0: accept at edge E -> o_valid first high after edge E+13, o_sample=-1, o_sat=0. o_in_ready low from E+1 until the result is consumed.
- y=3 -> o_sample=4 (f(3)=2, f(4)=3), o_sat=0. y=4094 -> 4095, o_sat=0. y=-4094 -> -4095, o_sat=0.
- y=5000 -> 4095, o_sat=1. y=-5000 -> -4095, o_sat=1.
- Backpressure: hold i_out_ready=0 for 20 cycles after o_valid -> o_valid, o_sample and o_sat stable. A new i_valid pulse during this time is not accepted. On i_out_ready=1 -> next cycle IDLE, o_in_ready=1.
- Reset mid-BUSY (deassert i_rst_n at cnt=6, asynchronously between edges) -> outputs are immediately o_valid=0, o_in_ready=1, o_sample=0. A fresh y=3 after reset release -> 4.
- Round-trip sweep: for every x in [-4095, 4095], y=f(x) from the bench model -> o_sample = smallest x' with f(x')=y, and f(o_sample)==y. o_sat=0 throughout.
